// File: rtl/led_seq_pkg.sv
// Shared types and constants for the LED cipher byte sequencer.
// Byte counts and counter widths used by the FSM and bit serdes.
package led_seq_pkg;

  localparam int KEY_BYTES   = 16;
  localparam int BLOCK_BYTES = 8;
  localparam int BIT_CNT_W   = 3;
  localparam int KEY_CNT_W   = 4;
  localparam int BLK_CNT_W   = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT_IN,
    S_START,
    S_WAIT,
    S_GET,
    S_OUT
  } state_e;

endpackage

// File: rtl/led_byte_sequencer_if.sv
// Host byte streams: input bytes (key/plaintext) and ciphertext output.
// master = host side, slave = sequencer side.
interface led_byte_sequencer_if;

  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_is_key;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;

  modport master (
    output in_valid, in_data, in_is_key, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_is_key, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/led_bit_serdes.sv
// 8-bit shift register with parallel load, MSB serial out, LSB serial in,
// plus a bit counter flagging the eighth shift.
module led_bit_serdes
  import led_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic [7:0] data_i,
  input  logic       shift_i,
  input  logic       ser_i,
  input  logic       clr_i,
  output logic       ser_o,
  output logic [7:0] data_o,
  output logic       last_o
);

  logic [7:0]           sr_q, sr_d;
  logic [BIT_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (load_i) begin
      sr_d  = data_i;
      cnt_d = '0;
    end else if (shift_i) begin
      sr_d  = {sr_q[6:0], ser_i};
      cnt_d = cnt_q + 1'b1;
    end else if (clr_i) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  assign ser_o  = sr_q[7];
  assign data_o = sr_q;
  assign last_o = &cnt_q;

endmodule

// File: rtl/led_byte_sequencer.sv
// Byte front end for the bit-serial LED-64/128 core: shifts key/pt bytes
// in MSB-first, runs one encryption, streams 8 ciphertext bytes back.
module led_byte_sequencer
  import led_seq_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  led_byte_sequencer_if.slave  bus,
  output logic                 busy,
  output logic                 key_loaded,
  output logic                 core_keyi,
  output logic                 core_datai,
  output logic                 core_loadkey,
  output logic                 core_loadpt,
  output logic                 core_getct,
  output logic                 core_start,
  input  logic                 core_dataq,
  input  logic                 core_done
);

  localparam logic [KEY_CNT_W-1:0] KEY_LAST =
    KEY_CNT_W'(KEY_BYTES - 1);
  localparam logic [BLK_CNT_W-1:0] BLK_LAST =
    BLK_CNT_W'(BLOCK_BYTES - 1);

  state_e               state_q;
  logic                 in_ready_q;
  logic                 out_valid_q;
  logic                 is_key_q;
  logic                 key_loaded_q;
  logic                 loadkey_q;
  logic                 loadpt_q;
  logic                 getct_q;
  logic                 start_q;
  logic                 armed_q;
  logic [KEY_CNT_W-1:0] key_cnt_q;
  logic [BLK_CNT_W-1:0] pt_cnt_q;
  logic [BLK_CNT_W-1:0] ct_cnt_q;

  logic       sd_load;
  logic       sd_shift;
  logic       sd_clr;
  logic       sd_msb;
  logic       sd_last;
  logic [7:0] sd_data;

  assign sd_load  = (state_q == S_IDLE) & bus.in_valid;
  assign sd_shift = (state_q == S_SHIFT_IN) | (state_q == S_GET);
  assign sd_clr   = (state_q == S_WAIT) | (state_q == S_OUT);

  led_bit_serdes u_serdes (
    .clk     (clk),
    .rst     (reset),
    .load_i  (sd_load),
    .data_i  (bus.in_data),
    .shift_i (sd_shift),
    .ser_i   (core_dataq & getct_q),
    .clr_i   (sd_clr),
    .ser_o   (sd_msb),
    .data_o  (sd_data),
    .last_o  (sd_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      is_key_q     <= 1'b0;
      key_loaded_q <= 1'b0;
      loadkey_q    <= 1'b0;
      loadpt_q     <= 1'b0;
      getct_q      <= 1'b0;
      start_q      <= 1'b0;
      armed_q      <= 1'b0;
      key_cnt_q    <= '0;
      pt_cnt_q     <= '0;
      ct_cnt_q     <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            is_key_q   <= bus.in_is_key;
            loadkey_q  <= bus.in_is_key;
            loadpt_q   <= ~bus.in_is_key;
            in_ready_q <= 1'b0;
            state_q    <= S_SHIFT_IN;
          end
        end
        S_SHIFT_IN: begin
          if (sd_last) begin
            loadkey_q <= 1'b0;
            loadpt_q  <= 1'b0;
            if (is_key_q) begin
              key_cnt_q  <= key_cnt_q + 1'b1;
              if (key_cnt_q == KEY_LAST)
                key_loaded_q <= 1'b1;
              in_ready_q <= 1'b1;
              state_q    <= S_IDLE;
            end else begin
              pt_cnt_q <= pt_cnt_q + 1'b1;
              if (pt_cnt_q == BLK_LAST) begin
                start_q <= 1'b1;
                state_q <= S_START;
              end else begin
                in_ready_q <= 1'b1;
                state_q    <= S_IDLE;
              end
            end
          end
        end
        S_START: begin
          start_q <= 1'b0;
          armed_q <= 1'b0;
          state_q <= S_WAIT;
        end
        // done is still high from the previous idle period; only a
        // low-then-high sequence marks the end of this encryption
        S_WAIT: begin
          if (!core_done) begin
            armed_q <= 1'b1;
          end else if (armed_q) begin
            getct_q <= 1'b1;
            state_q <= S_GET;
          end
        end
        S_GET: begin
          if (sd_last) begin
            getct_q     <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= S_OUT;
          end
        end
        S_OUT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            ct_cnt_q    <= ct_cnt_q + 1'b1;
            if (ct_cnt_q == BLK_LAST) begin
              in_ready_q <= 1'b1;
              state_q    <= S_IDLE;
            end else begin
              getct_q <= 1'b1;
              state_q <= S_GET;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = sd_data;
  assign busy          = ~in_ready_q;
  assign key_loaded    = key_loaded_q;
  assign core_keyi     = loadkey_q & sd_msb;
  assign core_datai    = loadpt_q & sd_msb;
  assign core_loadkey  = loadkey_q;
  assign core_loadpt   = loadpt_q;
  assign core_getct    = getct_q;
  assign core_start    = start_q;

endmodule

// File: tb/tb_led_byte_sequencer.sv
// Self-checking bench for led_byte_sequencer with a behavioural stand-in
// for the LED core and a byte-level reference for expected ciphertext.
module tb_led_byte_sequencer;
  import led_seq_pkg::*;

  localparam int START_TO_DONE = 2044;
  localparam logic [63:0] SALT = 64'h0123_4567_89AB_CDEF;
  localparam logic [10:0] RST_OUTS = 11'b100_0000_0000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic busy, key_loaded;
  logic core_keyi, core_datai;
  logic core_loadkey, core_loadpt;
  logic core_getct, core_start;
  logic core_dataq, core_done;

  int vectors = 0;
  int miscompares = 0;

  led_byte_sequencer_if bus();

  always #5 clk = ~clk;

  led_byte_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .busy         (busy),
    .key_loaded   (key_loaded),
    .core_keyi    (core_keyi),
    .core_datai   (core_datai),
    .core_loadkey (core_loadkey),
    .core_loadpt  (core_loadpt),
    .core_getct   (core_getct),
    .core_start   (core_start),
    .core_dataq   (core_dataq),
    .core_done    (core_done)
  );

  function automatic logic [63:0] ref_ct(
    input logic [127:0] k, input logic [63:0] p);
    return p ^ k[127:64] ^ {k[31:0], k[63:32]} ^ SALT;
  endfunction

  // stand-in core: serial key/pt registers, fixed latency, ct shift-out
  logic [127:0] c_key;
  logic [63:0]  c_pt, c_st;
  int           c_lat;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      c_key <= '0;
      c_pt  <= '0;
      c_st  <= '0;
      c_lat <= 0;
    end else begin
      if (core_loadkey) c_key <= {c_key[126:0], core_keyi};
      if (core_loadpt)  c_pt  <= {c_pt[62:0], core_datai};
      if (core_start) begin
        c_st  <= ref_ct(c_key, c_pt);
        c_lat <= START_TO_DONE - 1;
      end else if (c_lat != 0) begin
        c_lat <= c_lat - 1;
      end
      if (core_getct) c_st <= {c_st[62:0], 1'b0};
    end
  end

  assign core_done  = (c_lat == 0);
  assign core_dataq = c_st[63];

  int cyc = 0, n_lk = 0, n_lp = 0, n_st = 0, n_gc = 0;
  int n_excl = 0, n_idle = 0, start_cyc = 0, get_cyc = 0;
  bit get_pend = 0;

  always @(negedge clk) begin
    cyc++;
    n_lk += int'(core_loadkey);
    n_lp += int'(core_loadpt);
    n_st += int'(core_start);
    n_gc += int'(core_getct);
    if (int'(core_loadkey) + int'(core_loadpt) +
        int'(core_getct) + int'(core_start) > 1) n_excl++;
    if ((core_loadkey | core_loadpt | core_getct | core_start)
        && !core_done) n_idle++;
    if (core_start) begin
      start_cyc = cyc;
      get_pend  = 1;
    end
    if (core_getct && get_pend) begin
      get_cyc  = cyc;
      get_pend = 0;
    end
  end

  function automatic logic [10:0] outs();
    return {bus.in_ready, busy, bus.out_valid, key_loaded,
            core_keyi, core_datai, core_loadkey, core_loadpt,
            core_getct, core_start, |bus.out_data};
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    bus.in_valid = 0;
    bus.in_data = '0;
    bus.in_is_key = 0;
    bus.out_ready = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic k);
    int t = 0;
    while (!bus.in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    vectors++;
    if (!bus.in_ready) begin
      $display("FAIL send_timeout: in_ready=%0b required 1",
               bus.in_ready);
      miscompares++;
    end
    bus.in_valid = 1;
    bus.in_data = d;
    bus.in_is_key = k;
    @(posedge clk);
    #1 bus.in_valid = 0;
  endtask

  task automatic wait_ready(output int k);
    k = 0;
    while (!bus.in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic wait_start(input int st0);
    int k = 0;
    while (n_st == st0 && k < 20) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic collect_ct(input logic [63:0] exp, input int stall);
    int gc0 = n_gc;
    int t, gcs;
    logic [7:0] eb;
    for (int i = 0; i < BLOCK_BYTES; i++) begin
      eb = exp[63-8*i -: 8];
      t = 0;
      while (!bus.out_valid && t < 3000) begin
        @(negedge clk);
        t++;
      end
      vectors++;
      if (!bus.out_valid) begin
        $display("FAIL out_timeout byte %0d: out_valid=0 required 1", i);
        miscompares++;
        return;
      end
      if (i == 0) begin
        vectors++;
        if (get_cyc - start_cyc != START_TO_DONE + 1) begin
          $display("FAIL start_to_get: got %0d required %0d",
                   get_cyc - start_cyc, START_TO_DONE + 1);
          miscompares++;
        end
      end
      if (i == stall) begin
        gcs = n_gc;
        repeat (20) begin
          @(negedge clk);
          vectors++;
          if (!bus.out_valid || bus.out_data !== eb) begin
            $display("FAIL stall_hold: valid=%0b data=%h required 1 %h",
                     bus.out_valid, bus.out_data, eb);
            miscompares++;
          end
        end
        vectors++;
        if (n_gc != gcs) begin
          $display("FAIL stall_getct: got %0d required 0", n_gc - gcs);
          miscompares++;
        end
      end
      vectors++;
      if (bus.out_data !== eb) begin
        $display("FAIL ct_byte %0d: got %h required %h",
                 i, bus.out_data, eb);
        miscompares++;
      end
      bus.out_ready = 1;
      @(posedge clk);
      #1 bus.out_ready = 0;
    end
    vectors++;
    if (n_gc - gc0 != 64 || !bus.in_ready || busy) begin
      $display("FAIL ct_end: getct=%0d rdy=%0b busy=%0b required 64 1 0",
               n_gc - gc0, bus.in_ready, busy);
      miscompares++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (outs() !== RST_OUTS) begin
      $display("FAIL reset_outs: got %b required %b", outs(), RST_OUTS);
      miscompares++;
    end
  endtask

  task automatic test_key_load();
    int lk0 = n_lk, st0 = n_st, k;
    logic [127:0] ek = '0;
    for (int i = 0; i < KEY_BYTES; i++) begin
      ek = {ek[119:0], 8'(i)};
      send_byte(8'(i), 1'b1);
      if (i == 0) begin
        vectors++;
        if (!busy || bus.in_ready) begin
          $display("FAIL shift_busy: busy=%0b rdy=%0b required 1 0",
                   busy, bus.in_ready);
          miscompares++;
        end
      end
      wait_ready(k);
      if (i == 0) begin
        vectors++;
        if (k != 9) begin
          $display("FAIL throughput: got %0d required 9", k);
          miscompares++;
        end
      end
      if (i == KEY_BYTES - 2) begin
        vectors++;
        if (key_loaded !== 1'b0) begin
          $display("FAIL key_loaded_early: got %b required 0", key_loaded);
          miscompares++;
        end
      end
    end
    vectors++;
    if (key_loaded !== 1'b1) begin
      $display("FAIL key_loaded: got %b required 1", key_loaded);
      miscompares++;
    end
    vectors++;
    if (n_lk - lk0 != 128 || c_key !== ek) begin
      $display("FAIL key_stream: cycles=%0d bits=%h required 128 %h",
               n_lk - lk0, c_key, ek);
      miscompares++;
    end
    vectors++;
    if (n_st != st0) begin
      $display("FAIL key_no_start: got %0d required 0", n_st - st0);
      miscompares++;
    end
  endtask

  task automatic test_encrypt();
    int lk0, lp0 = n_lp, st0 = n_st, k;
    logic [127:0] key = 128'h0001_0203_0405_0607_0809_0A0B_0C0D_0E0F;
    logic [63:0] pt = '0;
    for (int i = 1; i <= BLOCK_BYTES; i++) begin
      pt = {pt[55:0], 8'(i)};
      send_byte(8'(i), 1'b0);
      if (i < BLOCK_BYTES) wait_ready(k);
    end
    wait_start(st0);
    vectors++;
    if (n_st - st0 != 1 || n_lp - lp0 != 64 || c_pt !== pt || !busy) begin
      $display("FAIL pt_load: st=%0d lp=%0d pt=%h busy=%0b required 1 64 %h 1",
               n_st - st0, n_lp - lp0, c_pt, busy, pt);
      miscompares++;
    end
    lk0 = n_lk;
    lp0 = n_lp;
    bus.in_valid = 1;
    bus.in_data = 8'hEE;
    bus.in_is_key = 1;
    repeat (30) begin
      @(negedge clk);
      vectors++;
      if (bus.in_ready || !busy) begin
        $display("FAIL wait_block: rdy=%0b busy=%0b required 0 1",
                 bus.in_ready, busy);
        miscompares++;
      end
    end
    bus.in_valid = 0;
    vectors++;
    if (n_lk != lk0 || n_lp != lp0 || n_st - st0 != 1) begin
      $display("FAIL wait_accept: lk=%0d lp=%0d st=%0d required 0 0 1",
               n_lk - lk0, n_lp - lp0, n_st - st0);
      miscompares++;
    end
    collect_ct(ref_ct(key, pt), 2);
  endtask

  task automatic test_zero_encrypt();
    int k;
    do_reset();
    for (int i = 0; i < KEY_BYTES; i++) begin
      send_byte(8'h00, 1'b1);
      wait_ready(k);
    end
    for (int i = 0; i < BLOCK_BYTES; i++) send_byte(8'h00, 1'b0);
    collect_ct(ref_ct('0, '0), -1);
    vectors++;
    if (n_excl != 0 || n_idle != 0) begin
      $display("FAIL strobe_excl: multi=%0d nonidle=%0d required 0 0",
               n_excl, n_idle);
      miscompares++;
    end
  endtask

  task automatic test_interleave();
    logic [7:0] kb[KEY_BYTES];
    logic [7:0] pb[BLOCK_BYTES];
    logic [127:0] key = '0;
    logic [63:0] pt = '0;
    bit isk[$];
    int idx[$];
    int lk0, lp0, st0, k;
    do_reset();
    for (int i = 0; i < KEY_BYTES; i++) begin
      kb[i] = 8'($urandom);
      key = {key[119:0], kb[i]};
    end
    for (int i = 0; i < BLOCK_BYTES; i++) begin
      pb[i] = 8'($urandom);
      pt = {pt[55:0], pb[i]};
    end
    for (int j = 0; j < 7; j++) begin
      isk.push_back(1); idx.push_back(j);
      isk.push_back(0); idx.push_back(j);
    end
    for (int j = 7; j < KEY_BYTES; j++) begin
      isk.push_back(1); idx.push_back(j);
    end
    isk.push_back(0); idx.push_back(7);
    st0 = n_st;
    for (int n = 0; n < isk.size(); n++) begin
      lk0 = n_lk;
      lp0 = n_lp;
      send_byte(isk[n] ? kb[idx[n]] : pb[idx[n]], isk[n]);
      if (n == isk.size() - 1) begin
        wait_start(st0);
        vectors++;
        if (n_st - st0 != 1 || n_lp - lp0 != 8 || !key_loaded) begin
          $display("FAIL il_start: st=%0d lp=%0d kl=%0b required 1 8 1",
                   n_st - st0, n_lp - lp0, key_loaded);
          miscompares++;
        end
      end else begin
        wait_ready(k);
        vectors++;
        if (n_lk - lk0 != (isk[n] ? 8 : 0) ||
            n_lp - lp0 != (isk[n] ? 0 : 8) || n_st != st0) begin
          $display("FAIL il_byte %0d: lk=%0d lp=%0d st=%0d key=%0b",
                   n, n_lk - lk0, n_lp - lp0, n_st - st0, isk[n]);
          miscompares++;
        end
      end
    end
    collect_ct(ref_ct(key, pt), -1);
  endtask

  task automatic test_reset_mid();
    int st0 = n_st, lk0, k;
    logic [7:0] d;
    for (int i = 0; i < BLOCK_BYTES; i++) send_byte(8'($urandom), 1'b0);
    wait_start(st0);
    repeat (10) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    vectors++;
    if (outs() !== RST_OUTS) begin
      $display("FAIL rst_wait: got %b required %b", outs(), RST_OUTS);
      miscompares++;
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    d = 8'($urandom);
    lk0 = n_lk;
    send_byte(d, 1'b1);
    wait_ready(k);
    vectors++;
    if (k != 9 || n_lk - lk0 != 8 || c_key[7:0] !== d) begin
      $display("FAIL rst_recover: k=%0d lk=%0d bits=%h required 9 8 %h",
               k, n_lk - lk0, c_key[7:0], d);
      miscompares++;
    end
    for (int i = 1; i < KEY_BYTES; i++) begin
      send_byte(8'($urandom), 1'b1);
      wait_ready(k);
    end
    vectors++;
    if (key_loaded !== 1'b1) begin
      $display("FAIL rst_reload: got %b required 1", key_loaded);
      miscompares++;
    end
    send_byte(8'hFF, 1'b1);
    repeat (4) @(posedge clk);
    #2;
    vectors++;
    if (core_loadkey !== 1'b1) begin
      $display("FAIL rst_bit4_pre: loadkey=%b required 1", core_loadkey);
      miscompares++;
    end
    reset = 1'b1;
    #1;
    vectors++;
    if (outs() !== RST_OUTS) begin
      $display("FAIL rst_shift: got %b required %b", outs(), RST_OUTS);
      miscompares++;
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    d = 8'($urandom);
    lk0 = n_lk;
    send_byte(d, 1'b1);
    wait_ready(k);
    vectors++;
    if (k != 9 || n_lk - lk0 != 8 || c_key[7:0] !== d || key_loaded) begin
      $display("FAIL rst_recover2: k=%0d lk=%0d bits=%h kl=%0b",
               k, n_lk - lk0, c_key[7:0], key_loaded);
      miscompares++;
    end
  endtask

  initial begin
    bus.in_valid = 0;
    bus.in_data = '0;
    bus.in_is_key = 0;
    bus.out_ready = 0;
    test_reset();
    test_key_load();
    test_encrypt();
    test_zero_encrypt();
    test_interleave();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/led_byte_sequencer.md
# led_byte_sequencer

Byte-wide host front end and sequencer for the bit-serial LED-64/128 block cipher core. Collects 16 key bytes and 8 plaintext bytes from a valid/ready stream and shifts them into the core MSB-first. Triggers an encryption, waits for completion, then streams 8 ciphertext bytes back out on a second valid/ready port. Sits between the SoC byte bus and the cipher core; the top level ties the core's active-low reset to `~reset`.

## Interface
- No parameters. Constants (`KEY_BYTES`=16, `BLOCK_BYTES`=8) live in the package.
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  host byte available.
- `in_ready`  out  1  sequencer accepts byte this cycle.
- `in_data`  in  8  host byte.
- `in_is_key`  in  1  1 = key byte, 0 = plaintext byte; qualified by `in_valid`.
- `out_valid`  out  1  ciphertext byte available.
- `out_ready`  in  1  host consumes byte.
- `out_data`  out  8  ciphertext byte.
- `busy`  out  1  high in any state except IDLE.
- `key_loaded`  out  1  set after 16 key bytes since reset; sticky.
- `core_keyi`, `core_datai`  out  1  serial key / plaintext bit to core.
- `core_loadkey`, `core_loadpt`, `core_getct`, `core_start`  out  1  core command strobes.
- `core_dataq`  in  1  core state bit 63.
- `core_done`  in  1  core idle flag.

## Operation
- Reset values: all outputs 0 except `in_ready`=1 (IDLE). Counters, the shift register and the state register are cleared, and `key_loaded`=0.
- States: IDLE, SHIFT_IN, START, WAIT, GET, OUT.
- IDLE
  - `in_ready`=1.
  - On handshake: latch `in_data` into the 8-bit shift register, latch `in_is_key`, clear the bit counter, and go to SHIFT_IN.
- SHIFT_IN (8 cycles)
  - Drive shift-register bit 7 on `core_keyi` (key) or `core_datai` (pt), with the matching `core_loadkey`/`core_loadpt`=1. Shift left each cycle.
  - After bit 0:
    - Key byte: key counter (4-bit, wraps 15→0) increments. Reaching 15→0 sets `key_loaded`. Go to IDLE.
    - Pt byte: pt counter (3-bit) increments. On 7→0 go to START, else IDLE.
- Interleaving: key and pt bytes may be freely interleaved. They target independent core shift registers.
- START: `core_start`=1 for exactly one cycle, all other strobes 0. Go to WAIT.
- WAIT: all strobes 0. Exit to GET when `core_done`=1. Encryption proceeds even if `key_loaded`=0; the core key is whatever was shifted in.
- GET (8 cycles)
  - `core_getct`=1.
  - Capture `core_dataq` into the shift-register LSB while shifting left. The first captured bit becomes `out_data[7]`.
  - Go to OUT.
- OUT: `out_valid`=1 with `out_data` stable until `out_ready`. On handshake, the ct counter increments. After the 8th byte go to IDLE, else GET.
- Strobe exclusivity: at most one `core_*` strobe is high in any cycle, and none is asserted unless the core is idle.
- Reset mid-operation: immediate return to the reset state. Any partially shifted key is discarded by the host rewriting all 16 bytes. `key_loaded` clears.

## Timing
- Input throughput: 1 byte per 9 cycles.
  - Handshake in cycle N.
  - Load strobes in N+1..N+8.
  - `in_ready` is high again in N+9.
- START follows the last pt shift cycle directly.
- The core reports done=1 combinationally, so done is still 1 in the START cycle. WAIT is entered the cycle after and must see done=0 before it can exit. Done is never sampled in START.
- Core latency is not counted by the sequencer. Nominal value is 2044 cycles from START to `core_done`=1.
- The first GET cycle immediately follows the WAIT exit.
- `out_valid` rises 8 cycles after GET entry and holds under backpressure with `out_data` unchanged.
- `in_ready`=0 from the first SHIFT_IN cycle until return to IDLE. `busy`=~`in_ready`.

## Structure
- `led_seq_pkg`: state enum, `KEY_BYTES`, `BLOCK_BYTES`, and the bit/byte counter widths (3, 4, 3).
- One sub-module, `led_bit_serdes`:
  - 8-bit shift register with parallel load, serial out (MSB), serial in (LSB), and a 3-bit bit counter with `last` flag.
  - Shared between SHIFT_IN and GET.
- The FSM, byte counters and `key_loaded` live in the top module.

## Test plan
- Reset, then 16 key bytes 0x00..0x0F: exactly 128 `core_loadkey` cycles with bit stream 0x000102…0F MSB-first; `key_loaded` rises after the 16th byte; no `core_start`.
- Key loaded, then 8 pt bytes 0x01..0x08: 64 `core_loadpt` cycles, then one `core_start` pulse; `busy`=1; `in_valid` held high during WAIT is not accepted.
- Full encryption, key=0 and pt=0, with the real core: 8 output bytes match the golden model. Also check the exact cycle count from `core_start` to the first GET, and that strobes are mutually exclusive.
- Hold `out_ready`=0 for 20 cycles on byte 3: `out_data` is stable, no `core_getct` occurs, and bytes 4..8 follow correctly once released.
- Interleave key, pt, key, pt… bytes: each goes to the correct strobe; START fires only after the 8th pt byte.
- Assert `reset` during WAIT and again during SHIFT_IN bit 4: all outputs return to reset values asynchronously; `key_loaded`=0; the next byte is accepted normally.
